// File: rtl/vld_rdy_buf.sv
// Valid/ready buffer stage: circular buffer of DEPTH payload entries with
// optional ready-cut, empty-bypass and synchronous flush.
module vld_rdy_buf #(
    parameter int unsigned DW        = 32,
    parameter int unsigned DEPTH     = 2,
    parameter bit          CUT_READY = 1'b0,
    parameter bit          PASS      = 1'b0,
    localparam int unsigned CW       = $clog2(DEPTH + 1),
    localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          vld_i,
    output logic          rdy_o,
    input  logic [DW-1:0] dat_i,
    output logic          vld_o,
    input  logic          rdy_i,
    output logic [DW-1:0] dat_o,
    output logic [CW-1:0] cnt_o
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic full;
    logic empty;
    logic bypass;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_en;

    // Pointers wrap explicitly so non-power-of-two depths stay in range.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Bypass only exists when there is nothing older queued, so order holds.
    assign bypass = PASS && empty && !flush_i;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        vld_o = 1'b0;
        dat_o = mem[rd_ptr];
        if (bypass) begin
            vld_o = vld_i;
            dat_o = dat_i;
        end else if (!flush_i) begin
            vld_o = !empty;
        end
    end

    always_comb begin
        rdy_o = 1'b0;
        if (!flush_i) begin
            if (CUT_READY) rdy_o = !full;
            else           rdy_o = !full || pop;
        end
    end

    assign push = vld_i && rdy_o;
    assign pop  = vld_o && rdy_i;

    // A bypassed beat that is consumed immediately never touches storage.
    assign wr_en = push && !(bypass && rdy_i);
    assign rd_en = pop && !bypass;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= next_ptr(wr_ptr);
            if (rd_en) rd_ptr <= next_ptr(rd_ptr);
            if (wr_en && !rd_en)      count <= count + CW'(1);
            else if (rd_en && !wr_en) count <= count - CW'(1);
        end
    end

    // NOTE: storage is reset here because dat_o must read 0 out of reset;
    // flush deliberately leaves the payloads in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= dat_i;
        end
    end

    assign cnt_o = count;

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && !rd_en && full));

    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_en && !wr_en && empty));

    a_hold_until_pop : assert property (@(posedge clk) disable iff (!rst_n)
        (vld_o && !rdy_i && !flush_i) |=> (flush_i || (vld_o && $stable(dat_o))));

endmodule

// File: tb/tb_vld_rdy_buf.sv
// Directed bench for vld_rdy_buf: four instances cover ready-cut, full
// throughput, odd depth wrap, bypass, flush and asynchronous reset.
module tb_vld_rdy_buf;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // 0: D2 cut, 1: D2 no-cut, 2: D3 no-cut, 3: D2 bypass
    logic [3:0]         flush = '0;
    logic [3:0]         vld_i = '0;
    logic [3:0]         rdy_i = '0;
    logic [3:0][DW-1:0] dat_i = '0;
    logic [3:0]         rdy_o;
    logic [3:0]         vld_o;
    logic [3:0][DW-1:0] dat_o;
    logic [3:0][1:0]    cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vld_rdy_buf #(.DW(DW), .DEPTH(2), .CUT_READY(1'b1), .PASS(1'b0)) u_cut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush[0]),
        .vld_i(vld_i[0]), .rdy_o(rdy_o[0]), .dat_i(dat_i[0]),
        .vld_o(vld_o[0]), .rdy_i(rdy_i[0]), .dat_o(dat_o[0]), .cnt_o(cnt[0]));

    vld_rdy_buf #(.DW(DW), .DEPTH(2), .CUT_READY(1'b0), .PASS(1'b0)) u_full (
        .clk(clk), .rst_n(rst_n), .flush_i(flush[1]),
        .vld_i(vld_i[1]), .rdy_o(rdy_o[1]), .dat_i(dat_i[1]),
        .vld_o(vld_o[1]), .rdy_i(rdy_i[1]), .dat_o(dat_o[1]), .cnt_o(cnt[1]));

    vld_rdy_buf #(.DW(DW), .DEPTH(3), .CUT_READY(1'b0), .PASS(1'b0)) u_odd (
        .clk(clk), .rst_n(rst_n), .flush_i(flush[2]),
        .vld_i(vld_i[2]), .rdy_o(rdy_o[2]), .dat_i(dat_i[2]),
        .vld_o(vld_o[2]), .rdy_i(rdy_i[2]), .dat_o(dat_o[2]), .cnt_o(cnt[2]));

    vld_rdy_buf #(.DW(DW), .DEPTH(2), .CUT_READY(1'b0), .PASS(1'b1)) u_pass (
        .clk(clk), .rst_n(rst_n), .flush_i(flush[3]),
        .vld_i(vld_i[3]), .rdy_o(rdy_o[3]), .dat_i(dat_i[3]),
        .vld_o(vld_o[3]), .rdy_i(rdy_i[3]), .dat_o(dat_o[3]), .cnt_o(cnt[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [29:0]   pat;
        logic [DW-1:0] q[$];
        int            sent;
        int            recv;
        logic          exp_rdy;

        // Reset state
        #2;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_vld%0d", i), 32'(vld_o[i]), 0);
            check($sformatf("rst_cnt%0d", i), 32'(cnt[i]), 0);
        end
        check("rst_dat0", 32'(dat_o[0]), 0);
        #10 rst_n = 1'b1;
        #1;
        check("rel_rdy0", 32'(rdy_o[0]), 1);
        check("rel_rdy1", 32'(rdy_o[1]), 1);

        // Test 1: cut-ready depth 2, fill then drain
        tick();
        vld_i[0] = 1'b1; dat_i[0] = 8'h11;
        #1;
        check("t1_rdy_empty", 32'(rdy_o[0]), 1);
        check("t1_latency", 32'(vld_o[0]), 0);
        tick();
        check("t1_cnt1", 32'(cnt[0]), 1);
        check("t1_vld1", 32'(vld_o[0]), 1);
        check("t1_dat_a", 32'(dat_o[0]), 32'h11);
        dat_i[0] = 8'h22;
        tick();
        vld_i[0] = 1'b0;
        check("t1_cnt2", 32'(cnt[0]), 2);
        check("t1_rdy_full", 32'(rdy_o[0]), 0);
        rdy_i[0] = 1'b1;
        #1;
        check("t1_rdy_cut", 32'(rdy_o[0]), 0);
        check("t1_out_a", 32'(dat_o[0]), 32'h11);
        tick();
        check("t1_out_b", 32'(dat_o[0]), 32'h22);
        check("t1_cnt_b", 32'(cnt[0]), 1);
        tick();
        rdy_i[0] = 1'b0;
        check("t1_cnt_0", 32'(cnt[0]), 0);
        check("t1_vld_0", 32'(vld_o[0]), 0);

        // Test 2: full with concurrent push/pop every cycle
        vld_i[1] = 1'b1; dat_i[1] = 8'h00;
        tick();
        dat_i[1] = 8'h01;
        tick();
        check("t2_full_rdy", 32'(rdy_o[1]), 0);
        check("t2_full_cnt", 32'(cnt[1]), 2);
        for (int i = 2; i < 8; i++) begin
            dat_i[1] = DW'(i);
            rdy_i[1] = 1'b1;
            #1;
            check($sformatf("t2_rdy%0d", i), 32'(rdy_o[1]), 1);
            check($sformatf("t2_cnt%0d", i), 32'(cnt[1]), 2);
            check($sformatf("t2_dat%0d", i), 32'(dat_o[1]), 32'(i - 2));
            tick();
        end
        vld_i[1] = 1'b0;
        #1;
        check("t2_dat6", 32'(dat_o[1]), 6);
        tick();
        check("t2_dat7", 32'(dat_o[1]), 7);
        check("t2_cnt_tail", 32'(cnt[1]), 1);
        tick();
        rdy_i[1] = 1'b0;
        check("t2_cnt_end", 32'(cnt[1]), 0);

        // Test 3: depth 3 stream with an irregular ready pattern
        pat  = 30'b11_1111_1111_1101_1100_1110_1011_1000;
        sent = 0;
        recv = 0;
        for (int c = 0; c < 30 && recv < 10; c++) begin
            rdy_i[2] = pat[c];
            vld_i[2] = (sent < 10);
            dat_i[2] = DW'(8'hA0 + sent);
            #1;
            exp_rdy = (q.size() < 3) || (q.size() > 0 && pat[c]);
            check($sformatf("t3_rdy_c%0d", c), 32'(rdy_o[2]), 32'(exp_rdy));
            check($sformatf("t3_cnt_c%0d", c), 32'(cnt[2]), 32'(q.size()));
            check($sformatf("t3_vld_c%0d", c), 32'(vld_o[2]), 32'(q.size() > 0));
            if (q.size() > 0 && pat[c]) begin
                check($sformatf("t3_dat_r%0d", recv), 32'(dat_o[2]), 32'(q[0]));
                void'(q.pop_front());
                recv++;
            end
            if (sent < 10 && exp_rdy) begin
                q.push_back(DW'(8'hA0 + sent));
                sent++;
            end
            tick();
        end
        vld_i[2] = 1'b0;
        rdy_i[2] = 1'b0;
        check("t3_all_recv", 32'(recv), 10);

        // Test 4: bypass when empty
        vld_i[3] = 1'b1; dat_i[3] = 8'hAB; rdy_i[3] = 1'b1;
        #1;
        check("t4_byp_vld", 32'(vld_o[3]), 1);
        check("t4_byp_dat", 32'(dat_o[3]), 32'hAB);
        check("t4_byp_rdy", 32'(rdy_o[3]), 1);
        tick();
        check("t4_byp_cnt", 32'(cnt[3]), 0);
        rdy_i[3] = 1'b0; dat_i[3] = 8'hCD;
        #1;
        check("t4_stall_vld", 32'(vld_o[3]), 1);
        check("t4_stall_dat", 32'(dat_o[3]), 32'hCD);
        tick();
        vld_i[3] = 1'b0; dat_i[3] = 8'h55;
        #1;
        check("t4_held_cnt", 32'(cnt[3]), 1);
        check("t4_held_vld", 32'(vld_o[3]), 1);
        check("t4_held_dat", 32'(dat_o[3]), 32'hCD);
        tick();
        check("t4_held2_dat", 32'(dat_o[3]), 32'hCD);
        rdy_i[3] = 1'b1;
        tick();
        rdy_i[3] = 1'b0;
        check("t4_pop_cnt", 32'(cnt[3]), 0);
        check("t4_pop_vld", 32'(vld_o[3]), 0);

        // Test 5: flush with push and pop requested
        vld_i[0] = 1'b1; dat_i[0] = 8'h31;
        tick();
        dat_i[0] = 8'h32;
        tick();
        check("t5_pre_cnt", 32'(cnt[0]), 2);
        flush[0] = 1'b1; rdy_i[0] = 1'b1;
        #1;
        check("t5_fl_rdy", 32'(rdy_o[0]), 0);
        check("t5_fl_vld", 32'(vld_o[0]), 0);
        tick();
        flush[0] = 1'b0; vld_i[0] = 1'b0; rdy_i[0] = 1'b0;
        #1;
        check("t5_post_cnt", 32'(cnt[0]), 0);
        check("t5_post_vld", 32'(vld_o[0]), 0);
        check("t5_post_rdy", 32'(rdy_o[0]), 1);

        // Test 6: asynchronous reset mid-stream
        vld_i[0] = 1'b1; dat_i[0] = 8'h41;
        tick();
        vld_i[0] = 1'b0;
        #1;
        check("t6_pre_cnt", 32'(cnt[0]), 1);
        check("t6_pre_vld", 32'(vld_o[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_vld", 32'(vld_o[0]), 0);
        check("t6_rst_dat", 32'(dat_o[0]), 0);
        check("t6_rst_cnt", 32'(cnt[0]), 0);
        rst_n = 1'b1;
        tick();
        vld_i[0] = 1'b1; dat_i[0] = 8'h5A;
        tick();
        vld_i[0] = 1'b0;
        #1;
        check("t6_new_vld", 32'(vld_o[0]), 1);
        check("t6_new_dat", 32'(dat_o[0]), 32'h5A);
        check("t6_new_cnt", 32'(cnt[0]), 1);
        rdy_i[0] = 1'b1;
        tick();
        rdy_i[0] = 1'b0;
        check("t6_end_cnt", 32'(cnt[0]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vld_rdy_buf.md
Name: vld_rdy_buf

Overview:
- Parametrised valid/ready buffer stage carrying a data payload, with configurable depth, ready-cut and bypass modes, and a synchronous flush.
- Next-generation replacement for the single-bit valid/ready stage in the debug and bus paths.
- Inserted between any producer/consumer pair to break timing or absorb back-pressure without losing or duplicating beats.

Parameters:
- DW, 32: payload width in bits.
- DEPTH, 2: number of storage entries; legal range 1..16.
- CUT_READY, 0: 1 = rdy_o depends only on registered state (no rdy_i->rdy_o path); 0 = accepts when full if a pop occurs in the same cycle.
- PASS, 0: 1 = when empty, input beats bypass combinationally to the output; 0 = every beat is registered.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear of all stored entries
- vld_i  in  1  upstream valid
- rdy_o  out  1  upstream ready
- dat_i  in  DW  upstream payload
- vld_o  out  1  downstream valid
- rdy_i  in  1  downstream ready
- dat_o  out  DW  downstream payload
- cnt_o  out  CW  number of stored entries, CW = clog2(DEPTH+1)

Behaviour:
- Reset (asynchronous on rst_n low):
  - Read/write pointers, count and all storage entries cleared to 0.
  - Outputs: vld_o=0, dat_o=0, cnt_o=0.
  - rdy_o=1 as soon as reset is released.
- Storage is a circular buffer of DEPTH entries with a write pointer, a read pointer and an occupancy count.
  - Pointers wrap from DEPTH-1 to 0; this must work for non-power-of-two DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
- Handshakes:
  - push = vld_i & rdy_o; pop = vld_o & rdy_i.
  - A beat transfers only on a cycle where both valid and ready are high.
  - Once vld_o is high it stays high, and dat_o holds stable, until the pop.
- Ready:
  - CUT_READY=1: rdy_o = ~full & ~flush_i.
  - CUT_READY=0: rdy_o = (~full | pop) & ~flush_i.
- Output, PASS=0:
  - vld_o = ~empty.
  - dat_o = entry at the read pointer.
  - Minimum latency is 1 cycle from push to vld_o.
- Output, PASS=1:
  - When empty and flush_i is low: vld_o = vld_i and dat_o = dat_i (0-cycle latency).
  - If rdy_i is also high, the beat passes through without being written and the count is unchanged.
  - If rdy_i is low, the beat is written and is held registered from the next cycle.
  - When not empty, behaviour is identical to PASS=0, which preserves ordering.
- Count update:
  - push & ~pop increments the count.
  - pop & ~push decrements it.
  - Push and pop together leave it unchanged and advance both pointers, including when full with CUT_READY=0.
  - An overflow or underflow of the count is impossible by construction; an assertion must flag it.
- Flush:
  - While flush_i is high, vld_o=0 and rdy_o=0, so no handshake occurs.
  - Pointers and count are 0 on the next edge.
  - Stored payloads are discarded; storage contents need not be cleared.
  - Flush has priority over push and pop.
- Reset asserted mid-transfer discards all entries immediately.
- DEPTH=1 with PASS=0 reproduces the legacy single-entry stage, with a DW-bit payload added.
- cnt_o is registered and reflects the count after the last edge.

Test Plan:
1. DEPTH=2, PASS=0, CUT_READY=1, rdy_i=0; push A=0x11 then B=0x22 -> cnt_o=2, rdy_o=0. Raise rdy_i for 2 cycles -> dat_o emits 0x11 then 0x22, cnt_o returns to 0.
2. DEPTH=2, CUT_READY=0, buffer full, vld_i=1 and rdy_i=1 held -> one push and one pop every cycle, rdy_o=1, cnt_o stays 2, order preserved over 8 beats (0x00..0x07).
3. DEPTH=3, PASS=0; stream 10 beats with random rdy_i -> pointers wrap past index 2; output sequence equals input sequence, no beat lost or duplicated.
4. PASS=1, empty, vld_i=1, dat_i=0xAB, rdy_i=1 -> vld_o=1 and dat_o=0xAB in the same cycle, cnt_o stays 0. Repeat with rdy_i=0 -> cnt_o=1 next cycle, vld_o held until popped.
5. cnt_o=2; assert flush_i together with vld_i=1 and rdy_i=1 -> rdy_o=0 and vld_o=0 during the flush cycle; next cycle cnt_o=0, vld_o=0, rdy_o=1.
6. Assert rst_n=0 mid-stream with cnt_o=1 -> vld_o=0, dat_o=0, cnt_o=0 immediately without waiting for a clock edge; after release, the first push appears correctly.
